// File: rtl/aud_recorder.sv
// I2S ADC capture: deserialises 16-bit left-channel samples on BCLK and emits them with SRAM
// write addresses. Define AUD_REC_STEREO_EN to also capture right-channel samples (L even, R odd).
module aud_recorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_adcdat,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_busy
);

  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWaitL  = 3'd1;
  localparam logic [2:0] StRecv   = 3'd2;
  localparam logic [2:0] StStore  = 3'd3;
  localparam logic [2:0] StPaused = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;
`ifdef AUD_REC_STEREO_EN
  localparam logic [2:0] StWaitR  = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic              lrc_prev_q, lrc_prev_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic              valid_q, valid_d;
`ifdef AUD_REC_STEREO_EN
  logic              chan_q, chan_d;
  logic              right_start;
  assign right_start = ~lrc_prev_q & i_lrc;
`endif

  logic left_start;
  assign left_start = lrc_prev_q & ~i_lrc;

  always_comb begin
    state_d    = state_q;
    lrc_prev_d = i_lrc;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    full_d     = full_q;
    valid_d    = 1'b0;
`ifdef AUD_REC_STEREO_EN
    chan_d     = chan_q;
`endif
    // Stop wins over everything; a partially shifted sample is simply dropped.
    if (i_stop) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d = StWaitL;
            ptr_d   = '0;
            len_d   = '0;
            full_d  = 1'b0;
          end
        end
        StWaitL: begin
          if (left_start) begin
            state_d = StRecv;
            cnt_d   = '0;
`ifdef AUD_REC_STEREO_EN
            chan_d  = 1'b0;
`endif
          end else if (i_pause && !i_start) begin
            state_d = StPaused;
          end
        end
`ifdef AUD_REC_STEREO_EN
        StWaitR: begin
          if (right_start) begin
            state_d = StRecv;
            cnt_d   = '0;
            chan_d  = 1'b1;
          end
        end
`endif
        StRecv: begin
          sr_d  = {sr_q[DATA_W-2:0], i_aud_adcdat};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_d = StStore;
          end
        end
        StStore: begin
          data_d  = sr_q;
          addr_d  = ptr_q;
          valid_d = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          len_d   = len_q + (ADDR_W + 1)'(1);
          if (ptr_q == MAX_ADDR) begin
            state_d = StDone;
            full_d  = 1'b1;
`ifdef AUD_REC_STEREO_EN
          end else if (!chan_q) begin
            state_d = StWaitR;
`endif
          end else if (i_pause) begin
            state_d = StPaused;
          end else begin
            state_d = StWaitL;
          end
        end
        StPaused: begin
          if (!i_pause && i_start) begin
            state_d = StWaitL;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      lrc_prev_q <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef AUD_REC_STEREO_EN
      chan_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lrc_prev_q <= lrc_prev_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
`ifdef AUD_REC_STEREO_EN
      chan_q     <= chan_d;
`endif
    end
  end

  assign o_data    = data_q;
  assign o_address = addr_q;
  assign o_valid   = valid_q;
  assign o_len     = len_q;
  assign o_full    = full_q;
  assign o_busy    = (state_q != StIdle) && (state_q != StDone);

endmodule
